// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and sequencer in front of the byte-addressable
// memory. Port 0 is instruction fetch (read-only), port 1 is data load/store.
// One request is in flight at a time and each accepted request gets exactly
// one single-cycle response pulse on its own port.
module mem_arbiter #(
    parameter int unsigned READ_WAIT = 2,
    parameter int unsigned TIMEOUT   = 255,
    parameter bit          RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_error,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [1:0]  req1_write,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_error,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_q,
    input  logic        mem_done,
    input  logic        mem_error
);

    // Last RD_WAIT count value (mem_q is sampled on that edge) and the
    // write-phase abort limit, both in counter width.
    localparam logic [7:0] RD_LAST_C = 8'(READ_WAIT - 1);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_WAIT    = 3'd1,
        ST_WR_WAIT    = 3'd2,
        ST_WR_RELEASE = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic        port_q;
    logic        err_q;
    logic [31:0] data_q;
    logic [7:0]  tcnt_q;
    logic [7:0]  rdcnt_q;
    logic [31:0] mem_address_q;
    logic [1:0]  mem_write_q;
    logic [31:0] mem_wdata_q;
    logic        rsp0_valid_q;
    logic [31:0] rsp0_data_q;
    logic        rsp0_error_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp1_data_q;
    logic        rsp1_error_q;

    logic        p1_eligible;
    logic        grant0;
    logic        grant1;
    logic [31:0] sel_addr;
    logic [1:0]  sel_write;
    logic [31:0] sel_wdata;
    logic [7:0]  tcnt_d;
    logic [7:0]  rdcnt_d;

    // A port-1 write must not start while the memory is still signalling DONE
    // from a previous (possibly reset-aborted) write; reads are never gated.
    assign p1_eligible = req1_valid && !((req1_write != 2'd0) && mem_done);

    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_write = grant1 ? req1_write : 2'd0;
    assign sel_wdata = grant1 ? req1_wdata : 32'd0;
    assign tcnt_d    = tcnt_q + 8'd1;
    assign rdcnt_d   = rdcnt_q + 8'd1;

    // Grant selection in IDLE: single requester wins, ties go round-robin
    // (or always to port 1 when round-robin is disabled).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            if (req0_valid && p1_eligible) begin
                if (RR_EN && (last_grant_q == 1'b1)) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (p1_eligible) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_data   = rsp0_data_q;
    assign rsp0_error  = rsp0_error_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_data   = rsp1_data_q;
    assign rsp1_error  = rsp1_error_q;
    assign mem_address = mem_address_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;

    // Sequencer FSM: latches the granted request, drives the memory
    // handshake, and emits the registered response pulse from RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b0;
            port_q        <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= 32'd0;
            tcnt_q        <= 8'd0;
            rdcnt_q       <= 8'd0;
            mem_address_q <= 32'd0;
            mem_write_q   <= 2'd0;
            mem_wdata_q   <= 32'd0;
            rsp0_valid_q  <= 1'b0;
            rsp0_data_q   <= 32'd0;
            rsp0_error_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_data_q   <= 32'd0;
            rsp1_error_q  <= 1'b0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        port_q  <= grant1;
                        rdcnt_q <= 8'd0;
                        tcnt_q  <= 8'd0;
                        data_q  <= 32'd0;
                        if (sel_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, memory untouched.
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else if (sel_write == 2'd0) begin
                            err_q         <= 1'b0;
                            mem_address_q <= sel_addr;
                            state_q       <= ST_RD_WAIT;
                        end else begin
                            err_q         <= 1'b0;
                            mem_address_q <= sel_addr;
                            mem_write_q   <= sel_write;
                            mem_wdata_q   <= sel_wdata;
                            state_q       <= ST_WR_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_error) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= err_q;
                    end
                    if (rdcnt_q == RD_LAST_C) begin
                        data_q  <= mem_q;
                        state_q <= ST_RESP;
                    end else begin
                        rdcnt_q <= rdcnt_d;
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_error) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q <= err_q;
                    end
                    if (mem_done) begin
                        mem_write_q <= 2'd0;
                        state_q     <= ST_WR_RELEASE;
                    end else if (tcnt_q == TIMEOUT_C) begin
                        mem_write_q <= 2'd0;
                        err_q       <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                ST_WR_RELEASE: begin
                    if (!mem_done) begin
                        state_q <= ST_RESP;
                    end else if (tcnt_q == TIMEOUT_C) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        tcnt_q <= tcnt_d;
                    end
                end
                ST_RESP: begin
                    if (port_q) begin
                        rsp1_valid_q <= 1'b1;
                        rsp1_data_q  <= data_q;
                        rsp1_error_q <= err_q;
                    end else begin
                        rsp0_valid_q <= 1'b1;
                        rsp0_data_q  <= data_q;
                        rsp0_error_q <= err_q;
                    end
                    last_grant_q <= port_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    mem_write_q <= 2'd0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small behavioural
// memory (one-register read path, programmable write/done handshake).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, rsp0_valid, rsp0_error;
    logic [31:0] req0_addr, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_error;
    logic [31:0] req1_addr, req1_wdata, rsp1_data;
    logic [1:0]  req1_write;
    logic [31:0] mem_address, mem_wdata, mem_q;
    logic [1:0]  mem_write;
    logic        mem_done, mem_error;

    // Second instance with round-robin disabled and a silent memory.
    logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic        b_rsp0_valid, b_rsp1_valid, b_rsp0_error, b_rsp1_error;
    logic [31:0] b_rsp0_data, b_rsp1_data, b_mem_address, b_mem_wdata;
    logic [1:0]  b_mem_write;

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic [31:0] mem [0:255];
    logic [31:0] rd_stage;
    logic        mem_init, pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          wr_delay, rel_delay, wcnt, rcnt;
    bit          stuck0;

    assign mem_q = rd_stage;

    mem_arbiter #(.READ_WAIT(2), .TIMEOUT(255), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_error(rsp0_error),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_error(rsp1_error),
        .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_q(mem_q), .mem_done(mem_done), .mem_error(mem_error)
    );

    mem_arbiter #(.READ_WAIT(2), .TIMEOUT(255), .RR_EN(1'b0)) dut_nr (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_addr(32'h0000_0200), .req0_ready(b_req0_ready),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data), .rsp0_error(b_rsp0_error),
        .req1_valid(b_req1_valid), .req1_addr(32'h0000_0300), .req1_write(2'd0),
        .req1_wdata(32'd0), .req1_ready(b_req1_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data), .rsp1_error(b_rsp1_error),
        .mem_address(b_mem_address), .mem_write(b_mem_write), .mem_wdata(b_mem_wdata),
        .mem_q(32'd0), .mem_done(1'b0), .mem_error(1'b0)
    );

    // Memory: read data one register behind the address; a write completes
    // wr_delay edges after it is seen, then DONE is held until mem_write
    // returns to 0 and for rel_delay further edges.
    always @(posedge clk) begin
        rd_stage <= mem[mem_address[9:2]];
        if (pl_en) mem[pl_idx] <= pl_data;
        if (mem_init || stuck0) begin
            mem_done <= 1'b0;
            wcnt     <= 0;
            rcnt     <= 0;
        end else if (!mem_done) begin
            rcnt <= 0;
            if (mem_write != 2'd0) begin
                if (wcnt >= wr_delay) begin
                    case (mem_write)
                        2'd1:    mem[mem_address[9:2]][31:24] <= mem_wdata[31:24];
                        2'd2:    mem[mem_address[9:2]][31:16] <= mem_wdata[31:16];
                        default: mem[mem_address[9:2]]        <= mem_wdata;
                    endcase
                    mem_done <= 1'b1;
                    wcnt     <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end else begin
            if (mem_write == 2'd0) begin
                if (rcnt >= rel_delay) begin
                    mem_done <= 1'b0;
                    rcnt     <= 0;
                end else begin
                    rcnt <= rcnt + 1;
                end
            end else begin
                rcnt <= 0;
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_idx = idx; pl_data = data; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present a request from a negedge until it is accepted; returns at the
    // first negedge after the acceptance edge.
    task automatic send(input int port, input logic [31:0] addr, input logic [1:0] wr,
                        input logic [31:0] wd, output bit ok);
        ok = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_addr = addr;
        end else begin
            req1_valid = 1'b1; req1_addr = addr; req1_write = wr; req1_wdata = wd;
        end
        for (int k = 0; k < 100; k++) begin
            #1;
            if ((port == 0) ? req0_ready : req1_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = 32'hFFFF_FFFF; req1_addr = 32'hFFFF_FFFF;
        req1_write = 2'd3; req1_wdata = 32'h5A5A_5A5A;
    endtask

    // Wait for a response on one port; lat=1 means visible at the current negedge.
    task automatic wait_rsp(input int port, input int limit, output int lat,
                            output logic [31:0] d, output logic e,
                            output int wr_cycles, output int other);
        lat = -1; d = 32'd0; e = 1'b0; wr_cycles = 0; other = 0;
        for (int k = 1; k <= limit; k++) begin
            if (mem_write != 2'd0) wr_cycles++;
            if ((port == 0) ? rsp1_valid : rsp0_valid) other++;
            if ((port == 0) ? rsp0_valid : rsp1_valid) begin
                lat = k;
                d   = (port == 0) ? rsp0_data : rsp1_data;
                e   = (port == 0) ? rsp0_error : rsp1_error;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        checks++; if (mem_write !== 2'd0) begin errors++; $display("FAIL reset_mem_write: got %0d expected 0", mem_write); end
        checks++; if (mem_address !== 32'd0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if ({rsp0_valid, rsp1_valid, rsp0_error, rsp1_error} !== 4'b0000) begin errors++; $display("FAIL reset_rsp: got %b expected 0000", {rsp0_valid, rsp1_valid, rsp0_error, rsp1_error}); end
        req0_valid = 1'b1; req1_valid = 1'b1; req1_write = 2'd0; req0_addr = 32'h0; req1_addr = 32'h0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        preload(8'h40, 32'h0BAD_F00D);
        send(0, 32'h0000_0100, 2'd0, 32'd0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fetch_accept: got %b expected 1", ok); end
        wait_rsp(0, 20, lat, d, e, wc, oth);
        checks++; if (lat !== 4) begin errors++; $display("FAIL fetch_latency: got %0d expected 4", lat); end
        checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL fetch_data: got %h expected 0badf00d", d); end
        checks++; if ({e, wc != 0, oth != 0} !== 3'b000) begin errors++; $display("FAIL fetch_side: got err=%b wr=%0d other=%0d expected 0 0 0", e, wc, oth); end
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_store_load();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        send(1, 32'h0000_0040, 2'd3, 32'hDEAD_BEEF, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL store_accept: got %b expected 1", ok); end
        checks++; if ({mem_write, mem_address, mem_wdata} !== {2'd3, 32'h40, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_drive: got w=%0d a=%h d=%h expected 3 40 deadbeef", mem_write, mem_address, mem_wdata); end
        wait_rsp(1, 40, lat, d, e, wc, oth);
        checks++; if (lat !== 7) begin errors++; $display("FAIL store_latency: got %0d expected 7", lat); end
        checks++; if (wc !== 3) begin errors++; $display("FAIL store_write_cycles: got %0d expected 3", wc); end
        checks++; if ({e, d} !== 33'd0) begin errors++; $display("FAIL store_rsp: got err=%b data=%h expected 0 0", e, d); end
        checks++; if (mem_write !== 2'd0) begin errors++; $display("FAIL store_release: got %0d expected 0", mem_write); end
        @(negedge clk);
        send(1, 32'h0000_0040, 2'd0, 32'd0, ok);
        wait_rsp(1, 20, lat, d, e, wc, oth);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", d); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL load_latency: got %0d expected 4", lat); end
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        preload(8'h10, 32'h1122_3344);
        send(1, 32'h0000_0040, 2'd1, 32'hAA55_6677, ok);
        wait_rsp(1, 40, lat, d, e, wc, oth);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL byte_store_err: got %b expected 0", e); end
        @(negedge clk);
        send(1, 32'h0000_0040, 2'd0, 32'd0, ok);
        wait_rsp(1, 20, lat, d, e, wc, oth);
        checks++; if (d !== 32'hAA22_3344) begin errors++; $display("FAIL byte_store_data: got %h expected aa223344", d); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        send(0, 32'h0000_0102, 2'd0, 32'd0, ok);
        wait_rsp(0, 20, lat, d, e, wc, oth);
        checks++; if ({lat == 2, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL misaligned_fetch: got lat=%0d err=%b data=%h expected 2 1 0", lat, e, d); end
        @(negedge clk);
        send(1, 32'h0000_0041, 2'd3, 32'h1111_2222, ok);
        wait_rsp(1, 20, lat, d, e, wc, oth);
        checks++; if ({lat == 2, e, wc == 0} !== 3'b111) begin errors++; $display("FAIL misaligned_store: got lat=%0d err=%b wr=%0d expected 2 1 0", lat, e, wc); end
        @(negedge clk);
    endtask

    task automatic test_mem_error();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        send(0, 32'h0000_0100, 2'd0, 32'd0, ok);
        mem_error = 1'b1;
        @(negedge clk);
        mem_error = 1'b0;
        wait_rsp(0, 20, lat, d, e, wc, oth);
        checks++; if ({lat == 3, e} !== 2'b11) begin errors++; $display("FAIL mem_error_rsp: got lat=%0d err=%b expected 3 1", lat, e); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int lat, wc, oth; logic [31:0] d; logic e;
        stuck0 = 1'b1;
        send(1, 32'h0000_0080, 2'd3, 32'hCAFE_0001, ok);
        wait_rsp(1, 400, lat, d, e, wc, oth);
        checks++; if (lat !== 258) begin errors++; $display("FAIL timeout_latency: got %0d expected 258", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", e); end
        checks++; if ({wc == 256, mem_write == 2'd0} !== 2'b11) begin errors++; $display("FAIL timeout_write: got wr_cycles=%0d mem_write=%0d expected 256 0", wc, mem_write); end
        stuck0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order[$]; int both, dual, b0, b1; logic [3:0] pat;
        both = 0; dual = 0; b0 = 0; b1 = 0; pat = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h100;
        req1_valid = 1'b1; req1_addr = 32'h40; req1_write = 2'd0;
        b_req0_valid = 1'b1; b_req1_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (req1_ready) order.push_back(1);
            if (req0_ready) order.push_back(0);
            if (req0_ready && req1_ready) both++;
            if (rsp0_valid && rsp1_valid) dual++;
            if (b_req0_ready) b0++;
            if (b_req1_ready) b1++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        repeat (8) @(negedge clk);
        if (order.size() >= 4) pat = {order[0][0], order[1][0], order[2][0], order[3][0]};
        checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL rr_order: got %b expected 1010", pat); end
        checks++; if ({both, dual} !== {32'd0, 32'd0}) begin errors++; $display("FAIL rr_exclusive: got both_ready=%0d both_rsp=%0d expected 0 0", both, dual); end
        checks++; if ((b0 != 0) || (b1 < 4)) begin errors++; $display("FAIL fixed_priority: got port0=%0d port1=%0d expected 0 and >=4", b0, b1); end
    endtask

    task automatic test_reset_in_write();
        bit ok; int lat, wc, oth, viol, rsp_seen; logic [31:0] d; logic e;
        bit acc1, r0acc, first_r0, first_r1;
        viol = 0; rsp_seen = 0; acc1 = 1'b0; r0acc = 1'b0; first_r0 = 1'b0; first_r1 = 1'b1;
        rel_delay = 8;
        send(1, 32'h0000_0080, 2'd3, 32'h1234_5678, ok);
        repeat (2) @(negedge clk);
        checks++; if ({mem_done, mem_write} !== {1'b1, 2'd3}) begin errors++; $display("FAIL rst_setup: got done=%b write=%0d expected 1 3", mem_done, mem_write); end
        reset = 1'b1;
        #1;
        checks++; if ({mem_write, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_drop: got write=%0d rsp=%b expected 0 0", mem_write, rsp1_valid); end
        @(negedge clk);
        reset = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h84; req1_write = 2'd3; req1_wdata = 32'h0F0F_0F0F;
        req0_valid = 1'b1; req0_addr = 32'h100;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (k == 0) begin first_r0 = req0_ready; first_r1 = req1_ready; end
            if (rsp1_valid) rsp_seen++;
            if (req1_ready && mem_done) viol++;
            if (req0_ready) r0acc = 1'b1;
            if (req1_ready) acc1 = 1'b1;
            @(negedge clk);
            if (r0acc) req0_valid = 1'b0;
            if (acc1) break;
        end
        req1_valid = 1'b0; req0_valid = 1'b0;
        checks++; if ({first_r0, first_r1} !== 2'b10) begin errors++; $display("FAIL gate_first: got ready0=%b ready1=%b expected 1 0", first_r0, first_r1); end
        checks++; if ({acc1, viol == 0, rsp_seen == 0} !== 3'b111) begin errors++; $display("FAIL gate_write: got acc=%b viol=%0d stale_rsp=%0d expected 1 0 0", acc1, viol, rsp_seen); end
        wait_rsp(1, 80, lat, d, e, wc, oth);
        checks++; if ({lat > 0, e} !== 2'b10) begin errors++; $display("FAIL gate_store_rsp: got lat=%0d err=%b expected >0 0", lat, e); end
        rel_delay = 0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1; pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;
        wr_delay = 1; rel_delay = 0; stuck0 = 1'b0; mem_error = 1'b0;
        req0_valid = 1'b0; req0_addr = 32'd0;
        req1_valid = 1'b0; req1_addr = 32'd0; req1_write = 2'd0; req1_wdata = 32'd0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        test_reset();
        test_fetch();
        test_store_load();
        test_byte_store();
        test_misaligned();
        test_mem_error();
        test_timeout();
        test_round_robin();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
